// File: rtl/cnn_pkg.sv
// ---- cnn_pkg : shared CNN layer types and dimensions (rev 1.0) ----
`default_nettype none

package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pool_state_t;

   localparam int L1_CHANNELS = 6;
   localparam int L1_COLUMNS  = 28;
   localparam int L1_IN_ROWS  = 28;

   // Counter width for n values, never below one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/max_pool_ctrl_if.sv
// ---- max_pool_ctrl_if : stream/pool handshake bundle (rev 1.0) ----
`default_nettype none

interface max_pool_ctrl_if
   import cnn_pkg::*;
#(
   parameter int COL_W = width_of(L1_COLUMNS),
   parameter int ROW_W = width_of(L1_IN_ROWS),
   parameter int CH_W  = width_of(L1_CHANNELS)
) ();

   logic             i_start;
   logic             i_valid;
   logic             o_ready;
   logic             o_pool_wr;
   logic             o_pool_bottom;
   logic [COL_W-1:0] o_pool_col;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [COL_W-2:0] o_out_col;
   logic [ROW_W-2:0] o_out_row;
   logic [CH_W-1:0]  o_chan;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_start, i_valid, i_out_ready,
      input  o_ready, o_pool_wr, o_pool_bottom, o_pool_col, o_out_valid,
             o_out_col, o_out_row, o_chan, o_busy, o_done
   );

   modport slave (
      input  i_start, i_valid, i_out_ready,
      output o_ready, o_pool_wr, o_pool_bottom, o_pool_col, o_out_valid,
             o_out_col, o_out_row, o_chan, o_busy, o_done
   );

endinterface

`default_nettype wire

// File: rtl/wrap_counter.sv
// ---- wrap_counter : modulo counter 0..MAX with wrap pulse for chaining (rev 1.0) ----
`default_nettype none

module wrap_counter #(
   parameter int MAX = 3,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = en && (cnt == W'(MAX));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/max_pool_ctrl.sv
// ---- max_pool_ctrl : sequencer for the streaming 2x2 / stride-2 max-pool datapath (rev 1.0) ----
`default_nettype none

module max_pool_ctrl
   import cnn_pkg::*;
#(
   parameter int NUM_CHANNELS = L1_CHANNELS,
   parameter int NUM_COLUMNS  = L1_COLUMNS,
   parameter int NUM_IN_ROWS  = L1_IN_ROWS,
   parameter int COL_W        = width_of(NUM_COLUMNS),
   parameter int ROW_W        = width_of(NUM_IN_ROWS),
   parameter int CH_W         = width_of(NUM_CHANNELS)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   max_pool_ctrl_if.slave bus
);

   pool_state_t      state;
   pool_state_t      state_nxt;
   logic             ready;
   logic             accept;
   logic             complete;
   logic             out_valid;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CH_W-1:0]  chan;
   logic             col_wrap;
   logic             row_wrap;
   logic             chan_wrap;
   logic [COL_W-2:0] out_col;
   logic [ROW_W-2:0] out_row;
   logic [CH_W-1:0]  out_chan;

   // Stall upstream only when a pooled value is pending and not leaving this cycle.
   assign ready    = (state == RUN) && !(out_valid && !bus.i_out_ready);
   assign accept   = bus.i_valid && ready;
   assign complete = accept && row[0] && col[0];

   wrap_counter #(.MAX(NUM_COLUMNS - 1), .W(COL_W)) u_col (
      .clk(i_clk), .rst(i_rst), .clr(state == IDLE), .en(accept),
      .cnt(col), .wrap(col_wrap)
   );

   wrap_counter #(.MAX(NUM_IN_ROWS - 1), .W(ROW_W)) u_row (
      .clk(i_clk), .rst(i_rst), .clr(state == IDLE), .en(col_wrap),
      .cnt(row), .wrap(row_wrap)
   );

   wrap_counter #(.MAX(NUM_CHANNELS - 1), .W(CH_W)) u_chan (
      .clk(i_clk), .rst(i_rst), .clr(state == IDLE), .en(row_wrap),
      .cnt(chan), .wrap(chan_wrap)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.i_start) state_nxt = RUN;
         RUN:     if (chan_wrap) state_nxt = DRAIN;
         DRAIN:   if (!out_valid || bus.i_out_ready) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One pending slot: a new completion may replace a value only as it is consumed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_valid <= 1'b0;
         out_col   <= '0;
         out_row   <= '0;
         out_chan  <= '0;
      end else if (complete) begin
         out_valid <= 1'b1;
         out_col   <= col[COL_W-1:1];
         out_row   <= row[ROW_W-1:1];
         out_chan  <= chan;
      end else if (bus.i_out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.o_ready       = ready;
   assign bus.o_pool_wr     = accept;
   assign bus.o_pool_bottom = row[0];
   assign bus.o_pool_col    = col;
   assign bus.o_out_valid   = out_valid;
   assign bus.o_out_col     = out_col;
   assign bus.o_out_row     = out_row;
   assign bus.o_chan        = out_chan;
   assign bus.o_busy        = (state == RUN) || (state == DRAIN);
   assign bus.o_done        = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_max_pool_ctrl.sv
// ---- tb_max_pool_ctrl : randomized self-checking bench for max_pool_ctrl (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_max_pool_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed { int ch; int r; int c; } pix_t;

   max_pool_ctrl_if #(.COL_W(2), .ROW_W(2), .CH_W(1)) sbus ();
   max_pool_ctrl_if #(.COL_W(5), .ROW_W(5), .CH_W(3)) dbus ();

   max_pool_ctrl #(.NUM_CHANNELS(2), .NUM_COLUMNS(4), .NUM_IN_ROWS(4)) u_small (
      .i_clk(clk), .i_rst(rst), .bus(sbus)
   );

   max_pool_ctrl u_dflt (
      .i_clk(clk), .i_rst(rst), .bus(dbus)
   );

   // 2x4x4 frame. mode 0: all high, 1: first pooled value stalled 5 cycles,
   // 2: i_valid toggling, 3: i_start pulsed in RUN and DRAIN. abort_at>0 returns early.
   task automatic run_small(input int mode, input int abort_at);
      pix_t exp_q[$];
      pix_t f;
      int   k = 0, outs = 0, dones = 0, cyc = 0, last_hs = -10;
      int   stalled = 0, drain_hold = 0, ready_low = 0;
      int   pc = 0, pr = 0, pch = 0;
      bit   prev_hold = 1'b0, exp_ov = 1'b0, exp_rdy, hs, completing;
      for (int ch = 0; ch < 2; ch++)
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
               exp_q.push_back('{ch: ch, r: r, c: c});
      @(negedge clk);
      sbus.i_start = 1'b1; sbus.i_valid = 1'b0; sbus.i_out_ready = 1'b1;
      @(negedge clk);
      sbus.i_start = 1'b0;
      while (cyc < 400) begin
         sbus.i_valid     = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
         sbus.i_out_ready = 1'b1;
         sbus.i_start     = 1'b0;
         if (mode == 1 && sbus.o_out_valid && stalled < 5) begin
            sbus.i_out_ready = 1'b0; stalled++;
         end
         if (mode == 3 && k == 5) sbus.i_start = 1'b1;
         if (mode == 3 && k == 32 && sbus.o_busy) begin
            sbus.i_start = 1'b1;
            if (drain_hold < 2) begin sbus.i_out_ready = 1'b0; drain_hold++; end
         end
         #1;
         hs      = sbus.o_out_valid && sbus.i_out_ready;
         exp_rdy = (k < 32) && !(exp_ov && !sbus.i_out_ready);
         vectors++;
         if (sbus.o_out_valid !== exp_ov) begin
            errors++; $display("FAIL out_valid m%0d cyc %0d: got %b want %b", mode, cyc, sbus.o_out_valid, exp_ov);
         end
         vectors++;
         if (sbus.o_ready !== exp_rdy) begin
            errors++; $display("FAIL ready m%0d cyc %0d: got %b want %b", mode, cyc, sbus.o_ready, exp_rdy);
         end
         vectors++;
         if (sbus.o_pool_wr !== (sbus.i_valid && exp_rdy)) begin
            errors++; $display("FAIL pool_wr m%0d cyc %0d: got %b want %b", mode, cyc, sbus.o_pool_wr, sbus.i_valid && exp_rdy);
         end
         if (k < 32 && sbus.o_busy && !sbus.o_ready) ready_low++;
         if (prev_hold) begin
            vectors++;
            if (sbus.o_out_valid !== 1'b1 || int'(sbus.o_out_col) != pc || int'(sbus.o_out_row) != pr || int'(sbus.o_chan) != pch) begin
               errors++; $display("FAIL hold m%0d cyc %0d: got v%b (%0d,%0d,%0d) want v1 (%0d,%0d,%0d)", mode, cyc,
                  sbus.o_out_valid, sbus.o_chan, sbus.o_out_row, sbus.o_out_col, pch, pr, pc);
            end
         end
         completing = 1'b0;
         if (sbus.i_valid && exp_rdy) begin
            vectors++;
            if (int'(sbus.o_pool_col) != k % 4 || int'(sbus.o_pool_bottom) != (k / 4) % 2) begin
               errors++; $display("FAIL beat m%0d k %0d: got col %0d bot %b want col %0d bot %0d", mode, k,
                  sbus.o_pool_col, sbus.o_pool_bottom, k % 4, (k / 4) % 2);
            end
            completing = ((k / 4) % 2 == 1) && (k % 2 == 1);
            k++;
         end
         if (hs) begin
            vectors++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL extra_out m%0d cyc %0d: got output want none", mode, cyc);
            end else begin
               f = exp_q.pop_front();
               if (int'(sbus.o_chan) != f.ch || int'(sbus.o_out_row) != f.r || int'(sbus.o_out_col) != f.c) begin
                  errors++; $display("FAIL out_idx m%0d #%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", mode, outs,
                     sbus.o_chan, sbus.o_out_row, sbus.o_out_col, f.ch, f.r, f.c);
               end
            end
            outs++; last_hs = cyc;
         end
         if (sbus.o_done) begin
            dones++; vectors++;
            if (cyc != last_hs + 1 || outs != 8) begin
               errors++; $display("FAIL done_time m%0d: got cyc %0d outs %0d want cyc %0d outs 8", mode, cyc, outs, last_hs + 1);
            end
         end
         prev_hold = sbus.o_out_valid && !sbus.i_out_ready;
         pc = int'(sbus.o_out_col); pr = int'(sbus.o_out_row); pch = int'(sbus.o_chan);
         exp_ov = completing ? 1'b1 : (hs ? 1'b0 : exp_ov);
         if (abort_at > 0 && k == abort_at) return;
         if (dones > 0 && cyc >= last_hs + 4) break;
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc >= 400) begin errors++; $display("FAIL timeout m%0d: got %0d cycles want <400", mode, cyc); end
      vectors++;
      if (dones != 1) begin errors++; $display("FAIL done_count m%0d: got %0d want 1", mode, dones); end
      vectors++;
      if (k != 32) begin errors++; $display("FAIL accepts m%0d: got %0d want 32", mode, k); end
      vectors++;
      if (outs != 8) begin errors++; $display("FAIL outputs m%0d: got %0d want 8", mode, outs); end
      if (mode == 1) begin
         vectors++;
         if (ready_low == 0 || stalled != 5) begin
            errors++; $display("FAIL stall m%0d: got ready_low %0d stalled %0d want >0 and 5", mode, ready_low, stalled);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({sbus.o_ready, sbus.o_out_valid, sbus.o_busy, sbus.o_done, sbus.o_out_col, sbus.o_out_row, sbus.o_chan} !== '0) begin
         errors++; $display("FAIL reset_small: got rdy%b ov%b busy%b done%b want all 0", sbus.o_ready, sbus.o_out_valid, sbus.o_busy, sbus.o_done);
      end
      vectors++;
      if ({dbus.o_ready, dbus.o_out_valid, dbus.o_busy, dbus.o_done, dbus.o_out_col, dbus.o_out_row, dbus.o_chan} !== '0) begin
         errors++; $display("FAIL reset_dflt: got rdy%b ov%b busy%b done%b want all 0", dbus.o_ready, dbus.o_out_valid, dbus.o_busy, dbus.o_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();           run_small(0, 0); endtask
   task automatic test_downstream_stall();  run_small(1, 0); endtask
   task automatic test_upstream_bubbles();  run_small(2, 0); endtask
   task automatic test_start_ignored();     run_small(3, 0); endtask

   task automatic test_reset_mid_frame();
      run_small(0, 13);
      @(negedge clk);
      rst = 1'b1; sbus.i_valid = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if ({sbus.o_ready, sbus.o_pool_wr, sbus.o_out_valid, sbus.o_busy, sbus.o_done,
           sbus.o_pool_col, sbus.o_pool_bottom, sbus.o_out_col, sbus.o_out_row, sbus.o_chan} !== '0) begin
         errors++; $display("FAIL mid_reset: got rdy%b ov%b busy%b col%0d want all 0", sbus.o_ready, sbus.o_out_valid, sbus.o_busy, sbus.o_pool_col);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (sbus.o_ready !== 1'b0 || sbus.o_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got rdy%b busy%b want 0 0", sbus.o_ready, sbus.o_busy);
         end
      end
      run_small(0, 0);
   endtask

   task automatic test_default_random();
      pix_t q[$];
      pix_t f, last;
      int   k = 0, outs = 0, dones = 0, cyc = 0;
      bit   exp_rdy;
      last = '{ch: -1, r: -1, c: -1};
      for (int ch = 0; ch < 6; ch++)
         for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++)
               q.push_back('{ch: ch, r: r, c: c});
      @(negedge clk);
      dbus.i_start = 1'b1; dbus.i_valid = 1'b0; dbus.i_out_ready = 1'b1;
      @(negedge clk);
      dbus.i_start = 1'b0;
      while (cyc < 40000 && dones == 0) begin
         dbus.i_valid     = ($urandom_range(0, 9) < 7);
         dbus.i_out_ready = ($urandom_range(0, 9) < 7);
         #1;
         exp_rdy = (k < 4704) && !(dbus.o_out_valid && !dbus.i_out_ready);
         vectors++;
         if (dbus.o_ready !== exp_rdy) begin
            errors++; $display("FAIL dflt_ready cyc %0d: got %b want %b", cyc, dbus.o_ready, exp_rdy);
         end
         if (dbus.i_valid && exp_rdy) begin
            vectors++;
            if (int'(dbus.o_pool_col) != k % 28 || int'(dbus.o_pool_bottom) != (k / 28) % 2) begin
               errors++; $display("FAIL dflt_beat k %0d: got col %0d bot %b want col %0d bot %0d", k,
                  dbus.o_pool_col, dbus.o_pool_bottom, k % 28, (k / 28) % 2);
            end
            k++;
         end
         if (dbus.o_out_valid && dbus.i_out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               errors++; $display("FAIL dflt_extra cyc %0d: got output want none", cyc);
            end else begin
               f = q.pop_front();
               if (int'(dbus.o_chan) != f.ch || int'(dbus.o_out_row) != f.r || int'(dbus.o_out_col) != f.c) begin
                  errors++; $display("FAIL dflt_idx #%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", outs,
                     dbus.o_chan, dbus.o_out_row, dbus.o_out_col, f.ch, f.r, f.c);
               end
            end
            last = '{ch: int'(dbus.o_chan), r: int'(dbus.o_out_row), c: int'(dbus.o_out_col)};
            outs++;
         end
         if (dbus.o_done) dones++;
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (dones != 1) begin errors++; $display("FAIL dflt_done: got %0d after %0d cycles want 1", dones, cyc); end
      vectors++;
      if (k != 4704) begin errors++; $display("FAIL dflt_accepts: got %0d want 4704", k); end
      vectors++;
      if (outs != 1176) begin errors++; $display("FAIL dflt_outputs: got %0d want 1176", outs); end
      vectors++;
      if (last.ch != 5 || last.r != 13 || last.c != 13) begin
         errors++; $display("FAIL dflt_last: got (%0d,%0d,%0d) want (5,13,13)", last.ch, last.r, last.c);
      end
   endtask

   initial begin
      sbus.i_start = 1'b0; sbus.i_valid = 1'b0; sbus.i_out_ready = 1'b0;
      dbus.i_start = 1'b0; dbus.i_valid = 1'b0; dbus.i_out_ready = 1'b0;
      test_reset();
      test_nominal();
      test_downstream_stall();
      test_upstream_bubbles();
      test_reset_mid_frame();
      test_start_ignored();
      test_default_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
